// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU result path.
package cpu8_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  // Writeback sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_WAIT = 2'd1,
    ST_CLEAR    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding packed {addr,data} writeback entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module result_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/result_writeback.sv
// Writeback stage: buffers results, replays them onto the register store
// write port, and runs a sequence that zeroes every register.
module result_writeback #(
  parameter int DATA_W = cpu8_pkg::DATA_W,
  parameter int ADDR_W = cpu8_pkg::REG_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              wb_stall,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              eo,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [7:0]        wr_count
);

  import cpu8_pkg::*;

  localparam int               EW       = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  wb_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic              r_eo, r_clr_done;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_wr_count;

  logic              w_full, w_empty, w_push, w_pop;
  logic [EW-1:0]     w_head;
  logic              w_clr_wr, w_clr_last;

  // Pushes only in IDLE so a clear never races new results; the FIFO still
  // drains in CLR_WAIT so the clear lands after every queued result.
  assign res_ready = ~w_full & (r_state == ST_IDLE);
  assign w_push    = res_valid & res_ready;
  assign w_pop     = ((r_state == ST_IDLE) || (r_state == ST_CLR_WAIT)) & ~w_empty & ~wb_stall;
  assign busy      = ~w_empty | (r_state != ST_IDLE);

  result_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({res_addr, res_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register and clear index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state, clear index stepping and clear-write strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clr_wr    = 1'b0;
    w_clr_last  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) w_state_nxt = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (w_empty) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (!wb_stall) begin
          w_clr_wr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_clr_last  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered store write port; addr/data hold when no write is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eo       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_eo       <= w_pop | w_clr_wr;
      r_clr_done <= w_clr_last;
      if (w_pop) begin
        r_addr <= w_head[EW-1:DATA_W];
        r_data <= w_head[DATA_W-1:0];
      end else if (w_clr_wr) begin
        r_addr <= r_idx;
        r_data <= '0;
      end
    end
  end

  // Saturating count of result writes; clear writes are not counted.
  always_ff @(posedge clk) begin
    if (rst)                             r_wr_count <= '0;
    else if (w_pop && r_wr_count != '1)  r_wr_count <= r_wr_count + 8'd1;
  end

  assign eo       = r_eo;
  assign addr     = r_addr;
  assign out_data = r_data;
  assign clr_done = r_clr_done;
  assign wr_count = r_wr_count;

endmodule
